// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory bus arbiter:
// one-hot state encodings, default bus widths and grant encodings.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 16;

    // One-hot arbiter states
    typedef enum logic [3:0] {
        QIdle    = 4'b0001,
        QGrant0  = 4'b0010,
        QGrant1  = 4'b0100,
        QRelease = 4'b1000
    } arb_state_t;

    // One-hot grant / pick encodings
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-input picker. Returns a one-hot pick among the active
// requests. Tie policy: round-robin on rr_ptr when ARB_RR_EN is defined,
// otherwise fixed priority to port 0.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] pick
);

`ifdef ARB_RR_EN
    // Tie goes to the port the pointer favours (the one not granted last)
    always_comb begin
        pick = GRANT_NONE;
        if (req == 2'b11)
            pick = rr_ptr ? GRANT_1 : GRANT_0;
        else if (req[0])
            pick = GRANT_0;
        else if (req[1])
            pick = GRANT_1;
    end
`else
    // Pointer has no meaning under fixed priority
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;

    // Port 0 always wins a tie
    always_comb begin
        pick = GRANT_NONE;
        if (req[0])
            pick = GRANT_0;
        else if (req[1])
            pick = GRANT_1;
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one block-wide memory between two caches.
// Grant is held until mem_done, followed by one release cycle before
// re-arbitration. Optional macro ARB_RR_EN selects round-robin tie
// breaking; by default port 0 has fixed priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_rd,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_done,
    input  logic              r1_rd,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic [1:0]        grant,
    output logic [7:0]        txn_count
);

    arb_state_t state_reg, state_next;
    logic [7:0] txn_count_reg;
    logic       txn_inc;
    logic [1:0] req;
    logic [1:0] pick;
    logic       rr_ptr;

    assign req = {r1_rd | r1_wr, r0_rd | r0_wr};

    arb_pick u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick)
    );

`ifdef ARB_RR_EN
    logic rr_ptr_reg;
    // Pointer favours the port that was not granted most recently
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr_reg <= 1'b0;
        else if (state_reg == QIdle && pick != GRANT_NONE)
            rr_ptr_reg <= pick[0];
    end
    assign rr_ptr = rr_ptr_reg;
`else
    assign rr_ptr = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= QIdle;
        else
            state_reg <= state_next;
    end

    // Completed-transaction counter, wraps modulo 256
    always_ff @(posedge clk) begin
        if (reset)
            txn_count_reg <= 8'd0;
        else if (txn_inc)
            txn_count_reg <= txn_count_reg + 8'd1;
    end

    // Next state and bus mux; mem_done outside a grant state is ignored
    always_comb begin
        state_next = state_reg;
        txn_inc    = 1'b0;
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        r0_done    = 1'b0;
        r1_done    = 1'b0;
        grant      = GRANT_NONE;
        case (state_reg)
            QIdle: begin
                if (pick[0])
                    state_next = QGrant0;
                else if (pick[1])
                    state_next = QGrant1;
            end
            QGrant0: begin
                grant     = GRANT_0;
                mem_addr  = r0_addr;
                mem_rd    = r0_rd;
                mem_wr    = r0_wr;
                mem_wdata = r0_wdata;
                r0_done   = mem_done;
                if (mem_done) begin
                    state_next = QRelease;
                    txn_inc    = 1'b1;
                end
            end
            QGrant1: begin
                grant     = GRANT_1;
                mem_addr  = r1_addr;
                mem_rd    = r1_rd;
                mem_wr    = r1_wr;
                mem_wdata = r1_wdata;
                r1_done   = mem_done;
                if (mem_done) begin
                    state_next = QRelease;
                    txn_inc    = 1'b1;
                end
            end
            QRelease: state_next = QIdle;
            default:  state_next = QIdle;
        endcase
    end

    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;
    assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter. Tie-break expectations
// follow ARB_RR_EN when the bench is built with that macro.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_rd = 1'b0, r0_wr = 1'b0;
    logic [4:0]  r0_addr = '0;
    logic [15:0] r0_wdata = '0;
    logic [15:0] r0_rdata;
    logic        r0_done;
    logic        r1_rd = 1'b0, r1_wr = 1'b0;
    logic [4:0]  r1_addr = '0;
    logic [15:0] r1_wdata = '0;
    logic [15:0] r1_rdata;
    logic        r1_done;
    logic [4:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done = 1'b0;
    logic [1:0]  grant;
    logic [7:0]  txn_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_model [0:31];

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_rd(r0_rd), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_done(r0_done),
        .r1_rd(r1_rd), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_done(r1_done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .grant(grant), .txn_count(txn_count)
    );

    // Memory model: combinational read, write committed on done
    assign mem_rdata = mem_model[mem_addr];
    always @(posedge clk) begin
        if (mem_wr && mem_done)
            mem_model[mem_addr] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %s ok value=%0h", tag, obs);
        end else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_grant [0:2];

    initial begin
        for (int i = 0; i < 32; i++) mem_model[i] = 16'(i);
        mem_model[5] = 16'h0a0b;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_txn", 32'(txn_count), 32'h0);
        chk("rst_mem_rd", 32'(mem_rd), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_done", 32'({r1_done, r0_done}), 32'h0);

        // Single read from r0, addr 5
        r0_rd = 1'b1; r0_addr = 5'd5;
        chk("rd_pre_grant", 32'(grant), 32'h0);
        tick();
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_mem_rd", 32'(mem_rd), 32'h1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h5);
        mem_done = 1'b1;
        #1;
        chk("rd_r0_done", 32'(r0_done), 32'h1);
        chk("rd_r0_rdata", 32'(r0_rdata), 32'h0a0b);
        chk("rd_r1_done", 32'(r1_done), 32'h0);
        tick();
        // Stale hold: r0_rd still high in release; stray mem_done ignored
        chk("rd_txn", 32'(txn_count), 32'h1);
        chk("rel_grant", 32'(grant), 32'h0);
        chk("rel_mem_rd", 32'(mem_rd), 32'h0);
        chk("rel_done_ignored", 32'({r1_done, r0_done}), 32'h0);
        mem_done = 1'b0;
        r0_rd = 1'b0;
        tick();
        chk("stale_idle_grant", 32'(grant), 32'h0);
        tick();
        chk("stale_no_second", 32'(grant), 32'h0);
        chk("stale_txn", 32'(txn_count), 32'h1);

        // Simultaneous requests from a fresh reset
        reset = 1'b1; tick(); reset = 1'b0;
        r0_rd = 1'b1; r0_addr = 5'd1;
        r1_wr = 1'b1; r1_addr = 5'd4; r1_wdata = 16'h0d0c;
        tick();
        chk("tie_first_grant", 32'(grant), 32'h1);
        chk("tie_first_addr", 32'(mem_addr), 32'h1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        r0_rd = 1'b0;
        chk("tie_release", 32'(grant), 32'h0);
        tick();
        chk("tie_idle", 32'(grant), 32'h0);
        tick();
        chk("tie_second_grant", 32'(grant), 32'h2);
        chk("tie_mem_wr", 32'(mem_wr), 32'h1);
        chk("tie_mem_addr", 32'(mem_addr), 32'h4);
        chk("tie_mem_wdata", 32'(mem_wdata), 32'h0d0c);
        mem_done = 1'b1;
        #1;
        chk("tie_r1_done", 32'(r1_done), 32'h1);
        chk("tie_r0_done", 32'(r0_done), 32'h0);
        tick();
        mem_done = 1'b0;
        r1_wr = 1'b0;
        chk("tie_mem4", 32'(mem_model[4]), 32'h0d0c);
        chk("tie_txn", 32'(txn_count), 32'h2);
        tick();

        // Continuous requests from both ports, three transactions
`ifdef ARB_RR_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01;
`endif
        r0_rd = 1'b1; r0_addr = 5'd2;
        r1_rd = 1'b1; r1_addr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("both_grant%0d", i), 32'(grant), 32'(exp_grant[i]));
            mem_done = 1'b1;
            #1;
            chk($sformatf("both_done%0d", i), 32'({r1_done, r0_done}), 32'(exp_grant[i]));
            tick();
            mem_done = 1'b0;
            tick();
        end
        chk("both_txn", 32'(txn_count), 32'h5);
        r0_rd = 1'b0; r1_rd = 1'b0;
        tick();

        // Reset in the middle of an r1 write
        r1_wr = 1'b1; r1_addr = 5'd7; r1_wdata = 16'h1234;
        tick();
        chk("mid_grant", 32'(grant), 32'h2);
        chk("mid_mem_wr", 32'(mem_wr), 32'h1);
        reset = 1'b1;
        r1_wr = 1'b0;
        tick();
        reset = 1'b0;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("mid_rst_txn", 32'(txn_count), 32'h0);
        chk("mid_rst_done", 32'({r1_done, r0_done}), 32'h0);
        chk("mid_mem7_kept", 32'(mem_model[7]), 32'h7);

        // Counter wrap after 256 completed transactions
        r0_rd = 1'b1; r0_addr = 5'd0;
        for (int i = 0; i < 256; i++) begin
            tick();
            mem_done = 1'b1;
            tick();
            mem_done = 1'b0;
            if (i == 254) chk("wrap_255", 32'(txn_count), 32'hff);
            tick();
        end
        r0_rd = 1'b0;
        chk("wrap_zero", 32'(txn_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
